// File: rtl/io_uart_tx_if.sv
// CPU I/O-space control signals seen by the serial output peripheral.
//   addr_bus : I/O address from the CPU MAR
//   mem_io   : high marks an I/O cycle
//   c_ri     : CPU write strobe (level)
//   c_ro     : CPU read strobe (level)
// The shared data bus is an inout and stays a plain port on the peripheral.
interface io_uart_tx_if;
    logic [7:0] addr_bus;
    logic       mem_io;
    logic       c_ri;
    logic       c_ro;

    modport master (
        output addr_bus,
        output mem_io,
        output c_ri,
        output c_ro
    );

    modport slave (
        input addr_bus,
        input mem_io,
        input c_ri,
        input c_ro
    );
endinterface

// File: rtl/io_uart_tx.sv
// Memory-mapped 8N1 serial transmitter with a small byte FIFO.
//   clk   : system clock, all state on posedge
//   reset : asynchronous active-high reset
//   cpu   : CPU I/O control (address, mem_io, write/read strobes)
//   bus   : shared data bus, driven only with the status byte during a status read
//   tx    : serial line, idle high
//   busy  : FIFO non-empty or a frame in progress
module io_uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 4,
    parameter int unsigned FIFO_DEPTH   = 4,
    parameter logic [7:0]  ADDR_DATA    = 8'h00,
    parameter logic [7:0]  ADDR_STATUS  = 8'h01
) (
    input  logic          clk,
    input  logic          reset,
    io_uart_tx_if.slave   cpu,
    inout  wire  [7:0]    bus,
    output logic          tx,
    output logic          busy
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned BT_W  = $clog2(CLKS_PER_BIT);
    localparam logic [BT_W-1:0]  BT_LAST  = BT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    // Bus decode and strobe edge detection
    logic wr, rd, wr_q, rd_q, push, rd_rise;

    assign wr      = cpu.mem_io & cpu.c_ri & (cpu.addr_bus == ADDR_DATA);
    assign rd      = cpu.mem_io & cpu.c_ro & (cpu.addr_bus == ADDR_STATUS);
    assign push    = wr & ~wr_q;
    assign rd_rise = rd & ~rd_q;

    // FIFO state
    logic [7:0]       mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full, empty, pop, push_ok;
    logic             overflow_q, overflow_d;

    assign full  = (count_q == CNT_FULL);
    assign empty = (count_q == '0);

    // Transmitter state
    state_t          state_q, state_d;
    logic [BT_W-1:0] bt_q, bt_d;
    logic [2:0]      bi_q, bi_d;
    logic [7:0]      shift_q, shift_d;
    logic            tx_q, tx_d;
    logic            bt_end;

    assign pop     = (state_q == S_IDLE) & ~empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands
    assign push_ok = push & (~full | pop);
    assign bt_end  = (bt_q == BT_LAST);

    // Status byte drives the bus only while a status read is active
    logic [7:0] status;
    assign status = {5'b0, overflow_q, full, busy};
    assign bus    = rd ? status : 8'hzz;

    assign busy = ~empty | (state_q != S_IDLE);
    assign tx   = tx_q;

    // Occupancy and sticky overflow; a same-cycle overflow beats the read clear
    always_comb begin
        count_d    = count_q;
        overflow_d = overflow_q;
        case ({push_ok, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        if (rd_rise) begin
            overflow_d = 1'b0;
        end
        if (push & ~push_ok) begin
            overflow_d = 1'b1;
        end
    end

    // FIFO storage needs no reset; pointers and count define validity
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= bus;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_q       <= 1'b0;
            rd_q       <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_q       <= wr;
            rd_q       <= rd;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
        end
    end

    // Transmitter state register; tx is registered with the state it belongs to
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            bt_q    <= '0;
            bi_q    <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            bt_q    <= bt_d;
            bi_q    <= bi_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
        end
    end

    // Next-state logic; tx_d is the line level of the state being entered
    always_comb begin
        state_d = state_q;
        bt_d    = bt_q;
        bi_d    = bi_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        case (state_q)
            S_IDLE: begin
                tx_d = 1'b1;
                if (!empty) begin
                    shift_d = mem_q[rd_ptr_q];
                    bt_d    = '0;
                    tx_d    = 1'b0;
                    state_d = S_START;
                end
            end
            S_START: begin
                bt_d = bt_q + BT_W'(1);
                if (bt_end) begin
                    bt_d    = '0;
                    bi_d    = '0;
                    tx_d    = shift_q[0];
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                bt_d = bt_q + BT_W'(1);
                if (bt_end) begin
                    bt_d    = '0;
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bi_q == 3'd7) begin
                        tx_d    = 1'b1;
                        state_d = S_STOP;
                    end else begin
                        bi_d = bi_q + 3'd1;
                        tx_d = shift_q[1];
                    end
                end
            end
            S_STOP: begin
                bt_d = bt_q + BT_W'(1);
                if (bt_end) begin
                    bt_d    = '0;
                    tx_d    = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

endmodule

// File: doc/io_uart_tx.md
Name: io_uart_tx

Overview:
Memory-mapped serial output peripheral on the CPU I/O space (mem_io high). The CPU writes bytes into a FIFO at ADDR_DATA and reads a status byte at ADDR_STATUS. A baud-divided transmitter drains the FIFO onto the 8N1 line tx. It sits directly downstream of the CPU's addr_bus/bus/c_ri/c_ro/mem_io outputs.

Parameters:
CLKS_PER_BIT, 4, clk cycles per serial bit (>=2)
FIFO_DEPTH, 4, FIFO entries (power of 2, >=2)
ADDR_DATA, 8'h00, I/O address of TX data register (write-only)
ADDR_STATUS, 8'h01, I/O address of status register (read-only)

Ports:
clk  in  1  system clock, all state on posedge
reset  in  1  asynchronous, active-high reset
addr_bus  in  8  I/O address from CPU MAR
mem_io  in  1  high = I/O cycle; block ignores bus activity when low
c_ri  in  1  CPU write strobe (level, may be held several clk cycles)
c_ro  in  1  CPU read strobe (level)
bus  inout  8  shared data bus; driven only during a status read, else Z
tx  out  1  serial line, idle high
busy  out  1  FIFO non-empty or frame in progress

Behaviour:
- Reset (async, immediate): tx=1, busy=0, FIFO empty (rd/wr pointers 0, count 0), FSM=IDLE, overflow=0, edge registers wr_q=rd_q=0, bus=Z. Reset mid-frame aborts the frame; tx rises at once.
- wr = mem_io & c_ri & (addr_bus==ADDR_DATA); rd = mem_io & c_ro & (addr_bus==ADDR_STATUS).
- Write edge: wr_q<=wr each clk. A push happens only on a clk where wr & ~wr_q, so one push per strobe assertion regardless of hold length. Data pushed = bus sampled on that edge.
- Push when full (and no pop that cycle): byte dropped, overflow<=1 (sticky).
- Status byte = {5'b0, overflow, full, busy}. Driven combinationally onto bus while rd=1; Z otherwise. Reads of ADDR_DATA do not drive the bus.
- Read edge: rd_q<=rd. On the rd & ~rd_q clk, overflow is cleared after the value is read. If an overflow occurs on the same clk, the set wins.
- Simultaneous push and pop: both are performed, count unchanged. This also applies when the FIFO is full, so the push is accepted and no overflow occurs.
- Pointers wrap modulo FIFO_DEPTH. count has width log2(FIFO_DEPTH)+1. full = count==FIFO_DEPTH; empty = count==0.
- FSM (registered tx, bit timer bt counts 0..CLKS_PER_BIT-1, bit index bi 0..7):
  IDLE: tx=1. If !empty: pop into shift reg, bt<=0, go START.
  START: tx=0. When bt==CLKS_PER_BIT-1: bt<=0, bi<=0, go DATA.
  DATA: tx=shift[0] (LSB first). At bt end, shift right. If bi==7 go STOP, else bi++.
  STOP: tx=1. At bt end go IDLE.
- Each state holds tx for exactly CLKS_PER_BIT clk. Back-to-back frames spend 1 clk in IDLE, so start-to-start spacing is 10*CLKS_PER_BIT+1 clk.
- Latency: with the push on posedge k into an empty FIFO, the pop and START transition occur at posedge k+1, and tx falls after posedge k+1.
- busy = !empty | (state!=IDLE), registered-consistent (derived from registered state).

Test Plan:
- Reset then idle 50 clk -> tx=1, busy=0, bus=Z, status read returns 8'h00.
- Write 8'hA5 (c_ri held 3 clk, mem_io=1, addr 8'h00), CLKS_PER_BIT=4 -> exactly one push. tx low 4 clk, then bits 1,0,1,0,0,1,0,1 at 4 clk each, then high 4 clk. busy drops the clk after STOP ends.
- Write 8'h01,8'h02,8'h03,8'h04,8'h05 in quick succession while the first frame is still in START -> first byte is popped, so all 5 are accepted (4 in FIFO + 1 shifting). Status then = 8'h03 (full, busy). Frames follow back to back with spacing 41 clk.
- Write 6 bytes before any pop can free a slot (hold reset-released FSM busy) -> 6th byte dropped, status = 8'h07. Second status read = 8'h03 (overflow cleared by the first read). Transmitted sequence excludes the dropped byte.
- Write with mem_io=0, or to addr 8'h01; read with addr 8'h00 -> no push, bus stays Z, tx stays 1.
- Assert reset during DATA bit 3 -> tx=1 immediately, FIFO empty, status 8'h00. A new write after release transmits a clean full frame.
